// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired Moore control unit: fetch, opcode dispatch and T-state strobes.
// Optional memory wait states on T1, ld-T6 and st-T7 when CTRL_MEM_WAIT_EN is defined.
module control_sequencer #(
  parameter int             OPW     = 5,
  parameter logic [OPW-1:0] ADDR_OP = 5'b00011
) (
  input  logic           Clock,
  input  logic           Clear,
  input  logic [31:0]    IR,
  input  logic           Stop,
`ifdef CTRL_MEM_WAIT_EN
  input  logic           MemReady,
`endif
  output logic           Gra,
  output logic           Grb,
  output logic           Grc,
  output logic           Rin,
  output logic           Rout,
  output logic           BAout,
  output logic           PCout,
  output logic           PCin,
  output logic           IncPC,
  output logic           IRin,
  output logic           MARin,
  output logic           MDRin,
  output logic           MDRout,
  output logic           Read,
  output logic           Write,
  output logic           Yin,
  output logic           Zin,
  output logic           ZHighout,
  output logic           ZLowout,
  output logic           HIin,
  output logic           LOin,
  output logic           Cout,
  output logic [OPW-1:0] ALU_op,
  output logic           Run
);

  localparam logic [3:0] ST_RST  = 4'd0;
  localparam logic [3:0] ST_T0   = 4'd1;
  localparam logic [3:0] ST_T1   = 4'd2;
  localparam logic [3:0] ST_T2   = 4'd3;
  localparam logic [3:0] ST_T3   = 4'd4;
  localparam logic [3:0] ST_T4   = 4'd5;
  localparam logic [3:0] ST_T5   = 4'd6;
  localparam logic [3:0] ST_T6   = 4'd7;
  localparam logic [3:0] ST_T7   = 4'd8;
  localparam logic [3:0] ST_HALT = 4'd9;

  localparam logic [2:0] CL_NOP  = 3'd0;
  localparam logic [2:0] CL_3R   = 3'd1;
  localparam logic [2:0] CL_IMM  = 3'd2;
  localparam logic [2:0] CL_NEG  = 3'd3;
  localparam logic [2:0] CL_MUL  = 3'd4;
  localparam logic [2:0] CL_LD   = 3'd5;
  localparam logic [2:0] CL_ST   = 3'd6;
  localparam logic [2:0] CL_HALT = 3'd7;

  // Unknown opcodes fall into CL_NOP so they fetch-and-skip like nop.
  function automatic logic [2:0] classify(input logic [OPW-1:0] op);
    if (op == OPW'(0))                          return CL_LD;
    else if (op == OPW'(2))                     return CL_ST;
    else if (op >= OPW'(3) && op <= OPW'(11))   return CL_3R;
    else if (op >= OPW'(12) && op <= OPW'(14))  return CL_IMM;
    else if (op == OPW'(15) || op == OPW'(16))  return CL_MUL;
    else if (op == OPW'(17) || op == OPW'(18))  return CL_NEG;
    else if (op == OPW'(27))                    return CL_HALT;
    else                                        return CL_NOP;
  endfunction

  logic [3:0]     state, nxt;
  logic [OPW-1:0] opc;
  logic [OPW-1:0] ir_op;
  logic [2:0]     cls, ir_cls;
  logic           mem_ready;
  logic           unused_ir;

  assign ir_op     = IR[31 -: OPW];
  assign unused_ir = ^IR[31-OPW:0];
  assign cls       = classify(opc);
  assign ir_cls    = classify(ir_op);

`ifdef CTRL_MEM_WAIT_EN
  assign mem_ready = MemReady;
`else
  assign mem_ready = 1'b1;
`endif

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state <= ST_RST;
      opc   <= '0;
    end else begin
      state <= nxt;
      if (state == ST_T2) opc <= ir_op;
    end
  end

  // Dispatch out of T2 uses IR directly since opc only captures it on that same edge.
  always_comb begin
    nxt = state;
    case (state)
      ST_RST:  nxt = ST_T0;
      ST_T0:   nxt = Stop ? ST_HALT : ST_T1;
      ST_T1:   nxt = mem_ready ? ST_T2 : ST_T1;
      ST_T2: begin
        if (ir_cls == CL_NOP)       nxt = ST_T0;
        else if (ir_cls == CL_HALT) nxt = ST_HALT;
        else                        nxt = ST_T3;
      end
      ST_T3:   nxt = ST_T4;
      ST_T4:   nxt = (cls == CL_NEG) ? ST_T0 : ST_T5;
      ST_T5:   nxt = (cls == CL_3R || cls == CL_IMM) ? ST_T0 : ST_T6;
      ST_T6: begin
        if (cls == CL_MUL)     nxt = ST_T0;
        else if (cls == CL_LD) nxt = mem_ready ? ST_T7 : ST_T6;
        else                   nxt = ST_T7;
      end
      ST_T7:   nxt = (cls == CL_ST && !mem_ready) ? ST_T7 : ST_T0;
      ST_HALT: nxt = ST_HALT;
      default: nxt = ST_RST;
    endcase
  end

  always_comb begin
    {Gra, Grb, Grc, Rin, Rout, BAout}                            = '0;
    {PCout, PCin, IncPC, IRin, MARin, MDRin, MDRout, Read, Write} = '0;
    {Yin, Zin, ZHighout, ZLowout, HIin, LOin, Cout}               = '0;
    ALU_op = '0;
    Run    = (state != ST_HALT);
    case (state)
      ST_T0: {PCout, MARin, IncPC} = 3'b111;
      ST_T1: {PCin, Read, MDRin}   = 3'b111;
      ST_T2: {MDRout, IRin}        = 2'b11;
      ST_T3: begin
        if (cls == CL_NEG)      begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; ALU_op = opc; end
        else if (cls == CL_MUL) begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
        else if (cls == CL_LD || cls == CL_ST) begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
        else                    begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
      end
      ST_T4: begin
        if (cls == CL_NEG)      begin ZLowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        else if (cls == CL_3R)  begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; ALU_op = opc; end
        else if (cls == CL_IMM) begin Cout = 1'b1; Zin = 1'b1; ALU_op = opc; end
        else if (cls == CL_MUL) begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; ALU_op = opc; end
        else                    begin Cout = 1'b1; Zin = 1'b1; ALU_op = ADDR_OP; end
      end
      ST_T5: begin
        ZLowout = 1'b1;
        if (cls == CL_MUL)                     LOin  = 1'b1;
        else if (cls == CL_LD || cls == CL_ST) MARin = 1'b1;
        else                                   begin Gra = 1'b1; Rin = 1'b1; end
      end
      ST_T6: begin
        if (cls == CL_MUL)     begin ZHighout = 1'b1; HIin = 1'b1; end
        else if (cls == CL_LD) begin Read = 1'b1; MDRin = 1'b1; end
        else                   begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
      end
      ST_T7: begin
        if (cls == CL_LD) begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        else              Write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - directed then randomized instruction stream checked against a micro-step queue model.
module tb_control_sequencer;

  logic        Clock = 1'b0;
  logic        Clear = 1'b0;
  logic        Stop  = 1'b0;
  logic [31:0] IR    = '0;
  logic Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC, IRin, MARin, MDRin, MDRout;
  logic Read, Write, Yin, Zin, ZHighout, ZLowout, HIin, LOin, Cout, Run;
  logic [4:0] ALU_op;

  always #5 Clock = ~Clock;

  control_sequencer dut (
    .Clock(Clock), .Clear(Clear), .IR(IR), .Stop(Stop),
`ifdef CTRL_MEM_WAIT_EN
    .MemReady(1'b1),
`endif
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .IRin(IRin), .MARin(MARin),
    .MDRin(MDRin), .MDRout(MDRout), .Read(Read), .Write(Write),
    .Yin(Yin), .Zin(Zin), .ZHighout(ZHighout), .ZLowout(ZLowout),
    .HIin(HIin), .LOin(LOin), .Cout(Cout), .ALU_op(ALU_op), .Run(Run)
  );

  localparam logic [27:0] COUT = 28'd1 << 0,  LOIN = 28'd1 << 1,  HIIN = 28'd1 << 2;
  localparam logic [27:0] ZLO  = 28'd1 << 3,  ZHI  = 28'd1 << 4,  ZIN  = 28'd1 << 5;
  localparam logic [27:0] YIN  = 28'd1 << 6,  WRT  = 28'd1 << 7,  READ = 28'd1 << 8;
  localparam logic [27:0] MDRO = 28'd1 << 9,  MDRI = 28'd1 << 10, MARI = 28'd1 << 11;
  localparam logic [27:0] IRIN = 28'd1 << 12, INCP = 28'd1 << 13, PCIN = 28'd1 << 14;
  localparam logic [27:0] PCO  = 28'd1 << 15, BAO  = 28'd1 << 16, ROUT = 28'd1 << 17;
  localparam logic [27:0] RIN  = 28'd1 << 18, GRC  = 28'd1 << 19, GRB  = 28'd1 << 20;
  localparam logic [27:0] GRA  = 28'd1 << 21, RUN  = 28'd1 << 27;

  int n_pass = 0, n_total = 0;

  task automatic check(input string tag, input logic [27:0] got, input logic [27:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h expected=%h", tag, got, exp);
  endtask

  function automatic logic [27:0] dut_vec();
    return {Run, ALU_op, Gra, Grb, Grc, Rin, Rout, BAout, PCout, PCin, IncPC, IRin, MARin,
            MDRin, MDRout, Read, Write, Yin, Zin, ZHighout, ZLowout, HIin, LOin, Cout};
  endfunction

  function automatic logic [27:0] alu(input logic [4:0] op);
    return {1'b0, op, 22'd0};
  endfunction

  logic [27:0] exp_q[$];
  int          kind_q[$];
  int          idx_q[$];
  logic [31:0] cur_ir;
  logic [4:0]  cur_op;
  bit          cur_stop, halted;
  int          cur_clr, halt_cnt, dir_i;

  logic [31:0] dir_ir[7]   = '{32'h90080000, 32'h18000000, 32'h00800000, 32'hD8000000,
                               32'h18000000, 32'h78000000, 32'h10000000};
  bit          dir_stop[7] = '{0, 0, 0, 0, 1, 0, 0};
  int          dir_clr[7]  = '{-1, -1, -1, -1, -1, 4, -1};

  task automatic push(input logic [27:0] v, input int kind);
    idx_q.push_back(kind_q.size() == 0 ? 0 : idx_q[$] + 1);
    exp_q.push_back(v);
    kind_q.push_back(kind);
  endtask

  task automatic flush();
    exp_q.delete(); kind_q.delete(); idx_q.delete();
  endtask

  task automatic next_instr();
    logic [4:0] op;
    if (dir_i < 7) begin
      cur_ir = dir_ir[dir_i]; cur_stop = dir_stop[dir_i]; cur_clr = dir_clr[dir_i];
      dir_i++;
    end else begin
      op = 5'($urandom_range(0, 31));
      cur_ir = {op, 27'($urandom)};
      cur_stop = ($urandom_range(0, 11) == 0);
      cur_clr = -1;
    end
    cur_op = cur_ir[31:27];
    op = cur_op;
    push(RUN | PCO | MARI | INCP, 1);
    if (cur_stop) begin halted = 1; return; end
    push(RUN | PCIN | READ | MDRI, 0);
    push(RUN | MDRO | IRIN, 2);
    if (op == 0 || op == 2) begin
      push(RUN | GRB | BAO | YIN, 0);
      push(RUN | COUT | ZIN | alu(5'b00011), 0);
      push(RUN | ZLO | MARI, 0);
      if (op == 0) begin
        push(RUN | READ | MDRI, 0);
        push(RUN | MDRO | GRA | RIN, 0);
      end else begin
        push(RUN | GRA | ROUT | MDRI, 0);
        push(RUN | WRT, 0);
      end
    end else if (op >= 3 && op <= 14) begin
      push(RUN | GRB | ROUT | YIN, 0);
      push(RUN | ((op <= 11) ? (GRC | ROUT) : COUT) | ZIN | alu(op), 0);
      push(RUN | ZLO | GRA | RIN, 0);
    end else if (op == 15 || op == 16) begin
      push(RUN | GRA | ROUT | YIN, 0);
      push(RUN | GRB | ROUT | ZIN | alu(op), 0);
      push(RUN | ZLO | LOIN, 0);
      push(RUN | ZHI | HIIN, 0);
    end else if (op == 17 || op == 18) begin
      push(RUN | GRB | ROUT | ZIN | alu(op), 0);
      push(RUN | ZLO | GRA | RIN, 0);
    end else if (op == 27) begin
      halted = 1;
    end
  endtask

  // Clear is raised between clock edges so the check at +1 proves the response is asynchronous.
  task automatic do_clear();
    Clear = 1'b1;
    #1 check("clear_async", dut_vec(), RUN);
    @(negedge Clock);
    check("clear_hold", dut_vec(), RUN);
    Clear = 1'b0;
    halted = 0; halt_cnt = 0;
    flush();
  endtask

  initial begin
    logic [27:0] e;
    int k, ix;
    halted = 0; halt_cnt = 0; dir_i = 0; cur_clr = -1; cur_op = '0;
    #2;
    do_clear();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge Clock);
      if (exp_q.size() == 0) begin
        if (halted && halt_cnt >= 22) begin
          do_clear();
          continue;
        end else if (halted) begin
          push(28'd0, 0);
          halt_cnt++;
        end else begin
          next_instr();
        end
      end
      e  = exp_q.pop_front();
      k  = kind_q.pop_front();
      ix = idx_q.pop_front();
      check($sformatf("op%0d step%0d", cur_op, ix), dut_vec(), e);
      Stop = (k == 1) ? cur_stop : 1'($urandom_range(0, 1));
      IR   = (k == 2) ? cur_ir : $urandom;
      if (!halted && (ix == cur_clr || (cur_clr < 0 && dir_i >= 7 && $urandom_range(0, 59) == 0))) begin
        cur_clr = -1;
        do_clear();
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
